// File: rtl/piso.sv
// Parallel-in / serial-out converter: loads a wide word and emits it as LSB-first slices.
// An active shift register plus one holding register let the next word queue without a bubble.
module piso #(
  parameter int DATA_IN_WIDTH  = 64,
  parameter int DATA_OUT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic [DATA_IN_WIDTH-1:0]  data_in,
  output logic                      in_ready,
  output logic                      out_valid,
  output logic [DATA_OUT_WIDTH-1:0] data_out,
  input  logic                      out_ready,
  output logic                      out_last
);

  localparam int NUM_SHIFTS = DATA_IN_WIDTH / DATA_OUT_WIDTH;
  localparam int CNT_W      = $clog2(NUM_SHIFTS) + 1;

  typedef enum logic [1:0] {
    EMPTY,
    SHIFTING,
    FULL
  } state_t;

  state_t                   state_q, state_d;
  logic [DATA_IN_WIDTH-1:0] active_q, active_d;
  logic [DATA_IN_WIDTH-1:0] hold_q, hold_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;

  logic in_xfer;
  logic out_xfer;
  logic last_slice;

  // in_ready depends only on registered state and reset, never on out_ready.
  assign in_ready   = reset && (state_q != FULL);
  assign out_valid  = (state_q != EMPTY);
  assign data_out   = active_q[DATA_OUT_WIDTH-1:0];
  assign last_slice = out_valid && (cnt_q == CNT_W'(NUM_SHIFTS - 1));
  assign out_last   = last_slice;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    hold_d   = hold_q;
    cnt_d    = cnt_q;
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          active_d = data_in;
          cnt_d    = '0;
          state_d  = SHIFTING;
        end
      end
      SHIFTING: begin
        if (out_xfer && last_slice) begin
          if (in_xfer) begin
            active_d = data_in;
            cnt_d    = '0;
          end else begin
            state_d = EMPTY;
          end
        end else begin
          if (out_xfer) begin
            active_d = active_q >> DATA_OUT_WIDTH;
            cnt_d    = cnt_q + CNT_W'(1);
          end
          if (in_xfer) begin
            hold_d  = data_in;
            state_d = FULL;
          end
        end
      end
      FULL: begin
        if (out_xfer) begin
          if (last_slice) begin
            active_d = hold_q;
            cnt_d    = '0;
            state_d  = SHIFTING;
          end else begin
            active_d = active_q >> DATA_OUT_WIDTH;
            cnt_d    = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= EMPTY;
      active_q <= '0;
      hold_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      hold_q   <= hold_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_piso.sv
// Randomized and directed bench for piso (64->16 and 16->16) against a slice-queue reference.
module tb_piso;

  logic        clk = 1'b0;
  logic        reset = 1'b0;

  logic        a_in_valid = 1'b0;
  logic [63:0] a_data_in = '0;
  logic        a_in_ready;
  logic        a_out_valid;
  logic [15:0] a_data_out;
  logic        a_out_ready = 1'b0;
  logic        a_out_last;

  logic        b_in_valid = 1'b0;
  logic [15:0] b_data_in = '0;
  logic        b_in_ready;
  logic        b_out_valid;
  logic [15:0] b_data_out;
  logic        b_out_ready = 1'b0;
  logic        b_out_last;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  piso #(.DATA_IN_WIDTH(64), .DATA_OUT_WIDTH(16)) u_a (
    .clk(clk), .reset(reset),
    .in_valid(a_in_valid), .data_in(a_data_in), .in_ready(a_in_ready),
    .out_valid(a_out_valid), .data_out(a_data_out), .out_ready(a_out_ready),
    .out_last(a_out_last)
  );

  piso #(.DATA_IN_WIDTH(16), .DATA_OUT_WIDTH(16)) u_b (
    .clk(clk), .reset(reset),
    .in_valid(b_in_valid), .data_in(b_data_in), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .data_out(b_data_out), .out_ready(b_out_ready),
    .out_last(b_out_last)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: a word is just its slices queued LSB first; words in flight = ceil(slices/4).
  typedef struct {
    logic [15:0] d;
    logic        last;
  } slice_t;

  slice_t      qa[$];
  slice_t      qb[$];
  logic [63:0] a_words[$];
  logic [63:0] a_asm = '0;
  int          a_idx = 0;

  always @(negedge clk) begin
    logic   exp_valid, exp_ready;
    slice_t s;
    if (!reset) begin
      chk("a_rst_valid", 64'(a_out_valid), 64'(0));
      chk("a_rst_last", 64'(a_out_last), 64'(0));
      chk("a_rst_data", 64'(a_data_out), 64'(0));
      chk("a_rst_ready", 64'(a_in_ready), 64'(0));
      qa.delete();
      a_words.delete();
      a_asm = '0;
      a_idx = 0;
    end else begin
      exp_valid = (qa.size() != 0);
      exp_ready = (((qa.size() + 3) / 4) < 2);
      chk("a_out_valid", 64'(a_out_valid), 64'(exp_valid));
      chk("a_in_ready", 64'(a_in_ready), 64'(exp_ready));
      if (exp_valid) begin
        chk("a_data_out", 64'(a_data_out), 64'(qa[0].d));
        chk("a_out_last", 64'(a_out_last), 64'(qa[0].last));
      end
      if (exp_valid && a_out_ready) begin
        s = qa.pop_front();
        a_asm = a_asm | (64'(s.d) << (16 * a_idx));
        a_idx++;
        if (s.last) begin
          if (a_words.size() != 0) chk("a_loopback", a_asm, a_words.pop_front());
          a_asm = '0;
          a_idx = 0;
        end
      end
      if (a_in_valid && exp_ready) begin
        a_words.push_back(a_data_in);
        for (int k = 0; k < 4; k++) begin
          s.d    = 16'((a_data_in >> (16 * k)) & 64'hFFFF);
          s.last = (k == 3);
          qa.push_back(s);
        end
      end
    end
  end

  always @(negedge clk) begin
    logic   exp_valid, exp_ready;
    slice_t s;
    if (!reset) begin
      chk("b_rst_valid", 64'(b_out_valid), 64'(0));
      chk("b_rst_ready", 64'(b_in_ready), 64'(0));
      qb.delete();
    end else begin
      exp_valid = (qb.size() != 0);
      exp_ready = (qb.size() < 2);
      chk("b_out_valid", 64'(b_out_valid), 64'(exp_valid));
      chk("b_in_ready", 64'(b_in_ready), 64'(exp_ready));
      if (exp_valid) begin
        chk("b_data_out", 64'(b_data_out), 64'(qb[0].d));
        chk("b_out_last", 64'(b_out_last), 64'(1));
      end
      if (exp_valid && b_out_ready) s = qb.pop_front();
      if (b_in_valid && exp_ready) begin
        s.d    = b_data_in;
        s.last = 1'b1;
        qb.push_back(s);
      end
    end
  end

  task automatic offer_a(input logic [63:0] w);
    logic acc;
    a_in_valid = 1'b1;
    a_data_in  = w;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      acc = a_in_ready;
      @(posedge clk);
      #1;
      if (acc) return;
    end
    chk("a_offer_timeout", 64'(1), 64'(0));
  endtask

  task automatic offer_b(input logic [15:0] w);
    logic acc;
    b_in_valid = 1'b1;
    b_data_in  = w;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      acc = b_in_ready;
      @(posedge clk);
      #1;
      if (acc) return;
    end
    chk("b_offer_timeout", 64'(1), 64'(0));
  endtask

  task automatic wait_slice_a(input logic [15:0] v);
    for (int t = 0; t < 50; t++) begin
      @(posedge clk);
      #1;
      if (a_out_valid && a_data_out == v) return;
    end
    chk("a_wait_timeout", 64'(1), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // 16/16: two words fill it, third waits until the consumer drains.
    fork
      begin
        offer_b(16'h0001);
        offer_b(16'h0002);
        offer_b(16'h0003);
        b_in_valid = 1'b0;
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        chk("b_full_ready", 64'(b_in_ready), 64'(0));
        @(posedge clk);
        #1;
        b_out_ready = 1'b1;
      end
    join
    repeat (6) @(posedge clk);
    #1;

    // Single word, LSB slice first, one cycle after accept.
    a_out_ready = 1'b1;
    offer_a(64'h4444_3333_2222_1111);
    a_in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("single_slice", 64'(a_data_out), 64'(16'h1111 * (k + 1)));
      chk("single_last", 64'(a_out_last), 64'(k == 3));
    end
    repeat (3) @(posedge clk);
    #1;

    // Back-to-back words.
    offer_a(64'hAAAA_AAAA_AAAA_AAAA);
    offer_a(64'hBBBB_BBBB_BBBB_BBBB);
    a_in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;

    // Backpressure on slice 2.
    offer_a(64'h4444_3333_2222_1111);
    a_in_valid = 1'b0;
    wait_slice_a(16'h2222);
    a_out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_hold_data", 64'(a_data_out), 64'(16'h2222));
      chk("bp_hold_last", 64'(a_out_last), 64'(0));
    end
    @(posedge clk);
    #1;
    a_out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;

    // Randomized traffic on both instances.
    for (int c = 0; c < 1500; c++) begin
      a_in_valid  = ($urandom_range(0, 3) != 0);
      a_data_in   = {$urandom, $urandom};
      a_out_ready = ($urandom_range(0, 3) != 0);
      b_in_valid  = ($urandom_range(0, 1) != 0);
      b_data_in   = 16'($urandom);
      b_out_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk);
      #1;
    end
    a_in_valid  = 1'b0;
    b_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    b_out_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("a_drained", 64'(qa.size()), 64'(0));
    chk("b_drained", 64'(qb.size()), 64'(0));

    // Reset mid-word with a second word held.
    offer_a(64'h4444_3333_2222_1111);
    a_in_valid = 1'b0;
    wait_slice_a(16'h2222);
    a_out_ready = 1'b0;
    offer_a(64'h8888_7777_6666_5555);
    a_in_valid = 1'b0;
    @(posedge clk);
    #3;
    chk("pre_rst_ready", 64'(a_in_ready), 64'(0));
    reset = 1'b0;
    #1;
    chk("async_rst_valid", 64'(a_out_valid), 64'(0));
    chk("async_rst_data", 64'(a_data_out), 64'(0));
    chk("async_rst_last", 64'(a_out_last), 64'(0));
    chk("async_rst_ready", 64'(a_in_ready), 64'(0));
    @(posedge clk);
    #1;
    reset = 1'b1;
    a_out_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("post_rst_idle", 64'(a_out_valid), 64'(0));
    end
    offer_a(64'h0123_4567_89AB_CDEF);
    a_in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
